// File: rtl/aim_servo_ctrl.sv
// Pan/tilt servo controller: once per frame it picks the lowest-index detected
// region, converts its pixel error from screen centre into a deadbanded,
// gain-scaled and clamped step, and applies it to two 50 Hz PWM outputs.
module aim_servo_ctrl #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int PWM_PERIOD = 500_000,
    parameter int POS_MIN    = 25_000,
    parameter int POS_MAX    = 50_000,
    parameter int POS_CENTER = 37_500,
    parameter int CENTER_X   = 320,
    parameter int CENTER_Y   = 240,
    parameter int DEADBAND   = 4,
    parameter int GAIN       = 20,
    parameter int MAX_STEP   = 1000,
    parameter bit PAN_INV    = 1'b0,
    parameter bit TILT_INV   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_sync,
    input  logic [15:0][9:0] aim_x_all,
    input  logic [15:0][9:0] aim_y_all,
    input  logic [15:0]      aim_detected_all,
    input  logic             target_off,
    output logic             pan_pwm,
    output logic             tilt_pwm,
    output logic [15:0]      pan_pos,
    output logic [15:0]      tilt_pos,
    output logic             track_valid,
    output logic             lock
);

    // Reject parameter sets that cannot produce a valid servo pulse.
    if (CLK_HZ < 1 || PWM_PERIOD <= POS_MAX || POS_MIN > POS_MAX) begin : g_bad_params
        $error("aim_servo_ctrl: inconsistent timing parameters");
    end

    localparam logic signed [11:0] CX_S    = 12'(CENTER_X);
    localparam logic signed [11:0] CY_S    = 12'(CENTER_Y);
    localparam logic signed [11:0] DB_S    = 12'(DEADBAND);
    localparam logic signed [23:0] GAIN_S  = 24'(GAIN);
    localparam logic signed [23:0] MAX_S24 = 24'(MAX_STEP);
    localparam logic signed [17:0] MAX_S18 = 18'(MAX_STEP);
    localparam logic signed [17:0] PMIN_S  = 18'(POS_MIN);
    localparam logic signed [17:0] PMAX_S  = 18'(POS_MAX);
    localparam logic signed [17:0] PCTR_S  = 18'(POS_CENTER);
    localparam logic [15:0]        PCTR_U  = 16'(POS_CENTER);
    localparam logic [31:0]        CNT_TOP = 32'(PWM_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SELECT, ERROR, STEP} state_t;

    state_t state, state_nxt;
    logic   v_sync_d;
    logic   frame_edge;

    logic [3:0]         sel_idx;
    logic               sel_found;
    logic [9:0]         aim_x_p0, aim_y_p0;
    logic               found_p0, toff_p0;
    logic signed [23:0] step_pan_p1, step_tilt_p1;

    logic [31:0] cnt;
    logic [15:0] pan_width, tilt_width;

    // Deadband, gain, clamp to +/-MAX_STEP, then optional axis inversion.
    function automatic logic signed [23:0] calc_step(input logic signed [11:0] err,
                                                     input logic inv);
        logic signed [11:0] mag;
        logic signed [23:0] prod;
        logic signed [23:0] lim;
        mag  = (err < 0) ? -err : err;
        prod = 24'(err) * GAIN_S;
        if (mag <= DB_S)
            lim = '0;
        else if (prod > MAX_S24)
            lim = MAX_S24;
        else if (prod < -MAX_S24)
            lim = -MAX_S24;
        else
            lim = prod;
        return inv ? -lim : lim;
    endfunction

    // Saturate a tentative position into the legal pulse-width range.
    function automatic logic [15:0] clamp_pos(input logic signed [17:0] v);
        if (v < PMIN_S)
            return 16'(PMIN_S);
        else if (v > PMAX_S)
            return 16'(PMAX_S);
        else
            return v[15:0];
    endfunction

    // Move one axis toward home by at most MAX_STEP, landing exactly on it.
    function automatic logic [15:0] toward_center(input logic [15:0] pos);
        logic signed [17:0] diff;
        diff = signed'({2'b00, pos}) - PCTR_S;
        if (diff > MAX_S18)
            return 16'(signed'({2'b00, pos}) - MAX_S18);
        else if (diff < -MAX_S18)
            return 16'(signed'({2'b00, pos}) + MAX_S18);
        else
            return PCTR_U;
    endfunction

    assign frame_edge = v_sync & ~v_sync_d;

    // Lowest set bit of the detected mask wins.
    always_comb begin
        sel_idx   = 4'd0;
        sel_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (aim_detected_all[i]) begin
                sel_idx   = 4'(i);
                sel_found = 1'b1;
            end
        end
    end

    // FSM state register and frame-sync delay.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            v_sync_d <= 1'b0;
        end else begin
            state    <= state_nxt;
            v_sync_d <= v_sync;
        end
    end

    // Next state: one pass per accepted frame edge, edges outside IDLE dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_edge) state_nxt = SELECT;
            SELECT:  state_nxt = ERROR;
            ERROR:   state_nxt = STEP;
            STEP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SELECT -> ERROR: capture the chosen target and the timeout flag.
    always_ff @(posedge clk) begin
        if (state == SELECT) begin
            aim_x_p0 <= aim_x_all[sel_idx];
            aim_y_p0 <= aim_y_all[sel_idx];
            found_p0 <= sel_found;
            toff_p0  <= target_off;
        end
    end

    // ERROR -> STEP: pixel error to per-axis step.
    always_ff @(posedge clk) begin
        if (state == ERROR) begin
            step_pan_p1  <= calc_step(signed'({2'b00, aim_x_p0}) - CX_S, PAN_INV);
            step_tilt_p1 <= calc_step(signed'({2'b00, aim_y_p0}) - CY_S, TILT_INV);
        end
    end

    // STEP -> IDLE: apply step, return home on timeout, or hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pan_pos     <= PCTR_U;
            tilt_pos    <= PCTR_U;
            track_valid <= 1'b0;
            lock        <= 1'b0;
        end else if (state == STEP) begin
            if (found_p0) begin
                pan_pos     <= clamp_pos(signed'({2'b00, pan_pos}) + 18'(step_pan_p1));
                tilt_pos    <= clamp_pos(signed'({2'b00, tilt_pos}) + 18'(step_tilt_p1));
                track_valid <= 1'b1;
                lock        <= (step_pan_p1 == '0) && (step_tilt_p1 == '0);
            end else begin
                if (toff_p0) begin
                    pan_pos  <= toward_center(pan_pos);
                    tilt_pos <= toward_center(tilt_pos);
                end
                track_valid <= 1'b0;
                lock        <= 1'b0;
            end
        end
    end

    // PWM period counter; widths latch only on the last count of a period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            pan_width  <= PCTR_U;
            tilt_width <= PCTR_U;
            pan_pwm    <= 1'b0;
            tilt_pwm   <= 1'b0;
        end else begin
            pan_pwm  <= (cnt < {16'd0, pan_width});
            tilt_pwm <= (cnt < {16'd0, tilt_width});
            if (cnt == CNT_TOP) begin
                cnt        <= '0;
                pan_width  <= pan_pos;
                tilt_width <= tilt_pos;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_aim_servo_ctrl.sv
// Directed bench for aim_servo_ctrl: a default instance, a pan-inverted
// instance and a small-timing instance share one set of stimulus inputs.
module tb_aim_servo_ctrl;

    logic             clk = 1'b0;
    logic             reset;
    logic             v_sync;
    logic [15:0][9:0] aim_x_all;
    logic [15:0][9:0] aim_y_all;
    logic [15:0]      aim_detected_all;
    logic             target_off;

    logic        pan_pwm, tilt_pwm, track_valid, lock;
    logic [15:0] pan_pos, tilt_pos;
    logic        i_pan_pwm, i_tilt_pwm, i_track_valid, i_lock;
    logic [15:0] i_pan_pos, i_tilt_pos;
    logic        s_pan_pwm, s_tilt_pwm, s_track_valid, s_lock;
    logic [15:0] s_pan_pos, s_tilt_pos;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aim_servo_ctrl dut (
        .clk(clk), .reset(reset), .v_sync(v_sync),
        .aim_x_all(aim_x_all), .aim_y_all(aim_y_all),
        .aim_detected_all(aim_detected_all), .target_off(target_off),
        .pan_pwm(pan_pwm), .tilt_pwm(tilt_pwm),
        .pan_pos(pan_pos), .tilt_pos(tilt_pos),
        .track_valid(track_valid), .lock(lock)
    );

    aim_servo_ctrl #(.PAN_INV(1'b1)) dut_inv (
        .clk(clk), .reset(reset), .v_sync(v_sync),
        .aim_x_all(aim_x_all), .aim_y_all(aim_y_all),
        .aim_detected_all(aim_detected_all), .target_off(target_off),
        .pan_pwm(i_pan_pwm), .tilt_pwm(i_tilt_pwm),
        .pan_pos(i_pan_pos), .tilt_pos(i_tilt_pos),
        .track_valid(i_track_valid), .lock(i_lock)
    );

    aim_servo_ctrl #(.PWM_PERIOD(300), .POS_MIN(100), .POS_MAX(200),
                     .POS_CENTER(150), .GAIN(1), .MAX_STEP(20)) dut_s (
        .clk(clk), .reset(reset), .v_sync(v_sync),
        .aim_x_all(aim_x_all), .aim_y_all(aim_y_all),
        .aim_detected_all(aim_detected_all), .target_off(target_off),
        .pan_pwm(s_pan_pwm), .tilt_pwm(s_tilt_pwm),
        .pan_pos(s_pan_pos), .tilt_pos(s_tilt_pos),
        .track_valid(s_track_valid), .lock(s_lock)
    );

    typedef struct {
        logic [15:0] det;
        int          ia, xa, ya;
        int          ib, xb, yb;
        logic        toff;
        int          pan, tilt;
        logic        tv, lk;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic set_aims(input logic [15:0] det, input int ia, input int xa, input int ya,
                            input int ib, input int xb, input int yb, input logic toff);
        @(negedge clk);
        aim_x_all        = '0;
        aim_y_all        = '0;
        aim_x_all[ia]    = 10'(xa);
        aim_y_all[ia]    = 10'(ya);
        aim_x_all[ib]    = 10'(xb);
        aim_y_all[ib]    = 10'(yb);
        aim_detected_all = det;
        target_off       = toff;
    endtask

    task automatic frame();
        @(negedge clk);
        v_sync = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int ph, th, sh;
        int hs [3];
        int ep, ei;

        tbl[0]  = '{16'h0120,  5, 322, 238,  8, 600, 400, 1'b0, 38500, 37500, 1'b1, 1'b1};
        tbl[1]  = '{16'h0001,  0, 420, 240,  0, 420, 240, 1'b0, 39500, 37500, 1'b1, 1'b0};
        tbl[2]  = '{16'h0001,  0, 420, 240,  0, 420, 240, 1'b0, 40500, 37500, 1'b1, 1'b0};
        tbl[3]  = '{16'h0000,  0, 420, 240,  0, 420, 240, 1'b0, 40500, 37500, 1'b0, 1'b0};
        tbl[4]  = '{16'h0000,  0, 420, 240,  0, 420, 240, 1'b1, 39500, 37500, 1'b0, 1'b0};
        tbl[5]  = '{16'h0000,  0, 420, 240,  0, 420, 240, 1'b1, 38500, 37500, 1'b0, 1'b0};
        tbl[6]  = '{16'h0000,  0, 420, 240,  0, 420, 240, 1'b1, 37500, 37500, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000,  0, 420, 240,  0, 420, 240, 1'b1, 37500, 37500, 1'b0, 1'b0};
        tbl[8]  = '{16'h8000, 15, 310, 245, 15, 310, 245, 1'b0, 37300, 37600, 1'b1, 1'b0};
        tbl[9]  = '{16'h0004,  2, 324, 236,  2, 324, 236, 1'b1, 37300, 37600, 1'b1, 1'b1};
        tbl[10] = '{16'h0000,  0,   0,   0,  0,   0,   0, 1'b1, 37500, 37500, 1'b0, 1'b0};
        tbl[11] = '{16'h0001,  0,   0,   0,  0,   0,   0, 1'b0, 36500, 36500, 1'b1, 1'b0};

        reset            = 1'b0;
        v_sync           = 1'b0;
        aim_x_all        = '0;
        aim_y_all        = '0;
        aim_detected_all = '0;
        target_off       = 1'b0;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pan_pos", 32'(pan_pos), 37500);
        check("rst_tilt_pos", 32'(tilt_pos), 37500);
        check("rst_pan_pwm", 32'(pan_pwm), 0);
        check("rst_tilt_pwm", 32'(tilt_pwm), 0);
        check("rst_track_valid", 32'(track_valid), 0);
        check("rst_lock", 32'(lock), 0);
        check("rst_s_pan_pos", 32'(s_pan_pos), 150);

        // First PWM period after release
        reset = 1'b1;
        ph = 0; th = 0; sh = 0;
        for (int i = 0; i < 38000; i++) begin
            @(negedge clk);
            if (pan_pwm) ph++;
            if (tilt_pwm) th++;
            if (i < 300 && s_pan_pwm) sh++;
        end
        check("first_period_pan_high", 32'(ph), 37500);
        check("first_period_tilt_high", 32'(th), 37500);
        check("small_first_period_high", 32'(sh), 150);

        // Latency: clamped step lands on the 4th edge, not before
        set_aims(16'h0001, 0, 420, 240, 0, 420, 240, 1'b0);
        @(negedge clk);
        v_sync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("latency_pan_before", 32'(pan_pos), 37500);
        @(posedge clk);
        #1;
        check("latency_pan_after", 32'(pan_pos), 38500);
        check("latency_tilt_after", 32'(tilt_pos), 37500);
        check("latency_track_valid", 32'(track_valid), 1);
        check("latency_lock", 32'(lock), 0);
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);

        // Table of successive frames (state carries from one row to the next)
        for (int v = 0; v < 12; v++) begin
            set_aims(tbl[v].det, tbl[v].ia, tbl[v].xa, tbl[v].ya,
                     tbl[v].ib, tbl[v].xb, tbl[v].yb, tbl[v].toff);
            frame();
            check($sformatf("vec%0d_pan_pos", v), 32'(pan_pos), 32'(tbl[v].pan));
            check($sformatf("vec%0d_tilt_pos", v), 32'(tilt_pos), 32'(tbl[v].tilt));
            check($sformatf("vec%0d_track_valid", v), 32'(track_valid), 32'(tbl[v].tv));
            check($sformatf("vec%0d_lock", v), 32'(lock), 32'(tbl[v].lk));
        end

        // Saturation at the pulse-width limits, normal and pan-inverted
        do_reset();
        set_aims(16'h0001, 0, 639, 479, 0, 639, 479, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            frame();
            ep = (37500 + 1000 * k > 50000) ? 50000 : 37500 + 1000 * k;
            ei = (37500 - 1000 * k < 25000) ? 25000 : 37500 - 1000 * k;
            check($sformatf("sat%0d_pan", k), 32'(pan_pos), 32'(ep));
            check($sformatf("sat%0d_tilt", k), 32'(tilt_pos), 32'(ep));
            check($sformatf("sat%0d_inv_pan", k), 32'(i_pan_pos), 32'(ei));
            check($sformatf("sat%0d_inv_tilt", k), 32'(i_tilt_pos), 32'(ep));
        end

        // Second edge two cycles after the first is dropped
        do_reset();
        set_aims(16'h0001, 0, 420, 240, 0, 420, 240, 1'b0);
        @(negedge clk) v_sync = 1'b1;
        @(negedge clk) v_sync = 1'b0;
        @(negedge clk) v_sync = 1'b1;
        @(negedge clk) v_sync = 1'b0;
        repeat (10) @(negedge clk);
        check("dropped_edge_pan", 32'(pan_pos), 38500);
        check("dropped_edge_track_valid", 32'(track_valid), 1);

        // Mid-period position change on the small instance
        set_aims(16'h0001, 0, 330, 240, 0, 330, 240, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        hs[0] = 0; hs[1] = 0; hs[2] = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (s_pan_pwm) hs[i / 300]++;
            if (i == 100) v_sync = 1'b1;
            if (i == 101) v_sync = 1'b0;
        end
        check("midperiod_cur_high", 32'(hs[0]), 150);
        check("midperiod_next_high", 32'(hs[1]), 160);
        check("midperiod_after_high", 32'(hs[2]), 160);
        check("midperiod_s_pan_pos", 32'(s_pan_pos), 160);
        check("midperiod_s_tilt_pos", 32'(s_tilt_pos), 150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aim_servo_ctrl.md
Name: aim_servo_ctrl

Overview:
- Consumes the per-frame tracker outputs (16-region aim centres, detected mask, target_off) and drives pan/tilt hobby servos to centre the tracked target on screen.
- Once per frame, a 4-state FSM picks the target, computes the pixel error from screen centre, and applies a deadbanded, gain-scaled, clamped step to two servo positions.
- Two 50 Hz PWM generators emit the pulses. New widths latch only at a PWM period boundary, so pulses never glitch.

Parameters:
- CLK_HZ, 25_000_000: clock frequency; informational only.
- PWM_PERIOD, 500_000: clocks per servo frame (20 ms).
- POS_MIN, 25_000: minimum pulse width in clocks (1 ms).
- POS_MAX, 50_000: maximum pulse width in clocks (2 ms).
- POS_CENTER, 37_500: home pulse width in clocks.
- CENTER_X, 320: screen-centre x.
- CENTER_Y, 240: screen-centre y.
- DEADBAND, 4: |error| ≤ DEADBAND pixels produces no step.
- GAIN, 20: clocks of pulse width per pixel of error.
- MAX_STEP, 1000: maximum |step| per frame, in clocks.
- PAN_INV, 0: 1 negates the pan step.
- TILT_INV, 0: 1 negates the tilt step.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- v_sync  in  1  frame sync; the rising edge triggers an update
- aim_x_all  in  [15:0][9:0]  per-region aim x
- aim_y_all  in  [15:0][9:0]  per-region aim y
- aim_detected_all  in  16  per-region valid mask
- target_off  in  1  no target for 3 s
- pan_pwm  out  1  pan servo pulse
- tilt_pwm  out  1  tilt servo pulse
- pan_pos  out  16  current pan pulse width (clocks)
- tilt_pos  out  16  current tilt pulse width (clocks)
- track_valid  out  1  a target was selected in the last update
- lock  out  1  last update had |err_x| ≤ DEADBAND and |err_y| ≤ DEADBAND with a target present

Behaviour:
- Everything resets only on clk edges with reset==0 (synchronous, active-low).
- Reset values:
  - pan_pos = tilt_pos = POS_CENTER.
  - Latched widths = POS_CENTER.
  - PWM counter = 0.
  - pan_pwm = tilt_pwm = 0.
  - track_valid = lock = 0.
  - FSM = IDLE.
  - v_sync delay register = 0.
- Frame edge: v_sync==1 while the registered v_sync_d==0.
  - Accepted only in IDLE.
  - An edge arriving in any other state is dropped.
- FSM:
  - IDLE → SELECT on an accepted edge.
  - SELECT (1 cycle): priority-encode aim_detected_all; the lowest set index k is the target. Register aim_x_all[k], aim_y_all[k], a found flag, and target_off.
  - ERROR (1 cycle):
    - err_x = aim_x − CENTER_X and err_y = aim_y − CENTER_Y, as signed 12-bit values.
    - Per axis: if |err| ≤ DEADBAND, step = 0; else step = clamp(err·GAIN, ±MAX_STEP), computed in signed 24-bit.
    - Apply the *_INV negation after the clamp.
  - STEP (1 cycle), then back to IDLE. Case order:
    - If found: pos ← clamp(pos + step, POS_MIN, POS_MAX), in signed 18-bit. track_valid ← 1. lock ← (both steps 0).
    - Else if target_off: each axis moves toward POS_CENTER by min(MAX_STEP, |pos − POS_CENTER|); exact arrival, no overshoot. track_valid ← 0. lock ← 0.
    - Else (lost but not timed out): positions hold. track_valid ← 0. lock ← 0.
  - found takes priority over target_off when both are set.
- Latency: pan_pos/tilt_pos update on the 4th clk edge after the edge where v_sync is first sampled high (IDLE→SELECT→ERROR→STEP→IDLE).
- Positive err_x with PAN_INV=0 increases pan_pos. Positive err_y with TILT_INV=0 increases tilt_pos.
- PWM:
  - Counter runs 0..PWM_PERIOD−1 and wraps.
  - When the counter equals PWM_PERIOD−1, latch pan_pos/tilt_pos into the width registers used for the next period.
  - pan_pwm = (cnt < pan_width), registered; same for tilt.
  - Each period therefore has exactly width high cycles, followed by low for the remainder.
  - A position change mid-period does not affect the current period.
- Reset mid-operation: the FSM aborts to IDLE and the PWM outputs drop to 0 on the next edge.

Test Plan:
- Reset: hold reset=0 for 5 cycles → pan_pos=tilt_pos=37_500; pwm outputs 0; track_valid=lock=0. After release, the first period has exactly 37_500 high cycles on each pwm.
- Detected=0x0001, aim=(420,240) → err_x=100, step=2000 clamped to 1000 → pan_pos=38_500 four cycles after the edge; tilt_pos=37_500; track_valid=1; lock=0.
- Detected=0x0120, region 5 aim=(322,238), region 8 aim=(600,400) → region 5 selected; within deadband → positions unchanged; lock=1.
- Target at (639,479) over 15 frames → pan_pos and tilt_pos saturate at 50_000 and never exceed it. PAN_INV=1 with the same stimulus → pan_pos saturates at 25_000.
- From pan_pos=40_500: detected=0, target_off=1 → 39_500, 38_500, 37_500, then holds at 37_500. With target_off=0 and detected=0 → hold at 40_500.
- Change pan_pos mid-period → the current period's high count is unchanged; the next period's high count equals the new pan_pos. A second v_sync edge 2 cycles after the first is dropped (a single step applied).
